// File: rtl/pio_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : pio_write_arbiter
// Description: Two-requester round-robin arbiter that sequences Avalon-MM
//              writes into a DATA_W-bit output PIO data register and keeps a
//              shadow copy of the last value written.
//              Optional readback check: define PIO_WRITE_ARBITER_READBACK_EN
//              to read each written value back and flag mismatches on rb_err.
// Revision   : 1.0 - initial release
// ============================================================================
module pio_write_arbiter #(
    parameter int DATA_W   = 2,
    parameter int PIO_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              ack_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_b,
    output logic [1:0]        av_address,
    output logic              av_chipselect,
    output logic              av_write_n,
    output logic [31:0]       av_writedata,
    input  logic [31:0]       av_readdata,
    output logic              busy,
    output logic              last_grant,
    output logic [DATA_W-1:0] shadow
`ifdef PIO_WRITE_ARBITER_READBACK_EN
    ,
    output logic              rb_err
`endif
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_write = 2'd1;
`ifdef PIO_WRITE_ARBITER_READBACK_EN
    localparam logic [1:0] c_read  = 2'd2;
`endif
    localparam logic [1:0] c_ack   = 2'd3;

    localparam logic [1:0] c_pio_addr = 2'(PIO_ADDR);

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_wbuf;
    logic              r_last_grant;
    logic [DATA_W-1:0] r_shadow;
    logic              w_grant_b;
    logic              w_bus_active;
    logic [31:0]       w_wdata_ext;
    logic              w_unused_readdata;

    // Under contention the requester that was not served last wins; a lone
    // requester always wins.
    assign w_grant_b = req_b && (!req_a || !r_last_grant);

    // Zero-extend the payload onto the 32-bit Avalon data bus.
    generate
        if (DATA_W < 32) begin : g_pad
            assign w_wdata_ext = {{(32-DATA_W){1'b0}}, r_wbuf};
        end else begin : g_nopad
            assign w_wdata_ext = r_wbuf;
        end
    endgenerate

    // Main sequencer: grant, latch payload, drive the bus, acknowledge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_idle;
            r_wbuf       <= '0;
            r_last_grant <= 1'b1;
            r_shadow     <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (req_a || req_b) begin
                        r_state      <= c_write;
                        r_last_grant <= w_grant_b;
                        r_wbuf       <= w_grant_b ? wdata_b : wdata_a;
                    end
                end
                c_write: begin
                    // Zero-wait-state slave: the write commits at this edge.
                    r_shadow <= r_wbuf;
`ifdef PIO_WRITE_ARBITER_READBACK_EN
                    r_state  <= c_read;
`else
                    r_state  <= c_ack;
`endif
                end
`ifdef PIO_WRITE_ARBITER_READBACK_EN
                c_read: begin
                    r_state <= c_ack;
                end
`endif
                c_ack: begin
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

`ifdef PIO_WRITE_ARBITER_READBACK_EN
    logic r_rb_err;

    // Sticky readback-mismatch flag, sampled at the end of the READ cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rb_err <= 1'b0;
        end else if ((r_state == c_read) && (av_readdata[DATA_W-1:0] != r_wbuf)) begin
            r_rb_err <= 1'b1;
        end
    end

    assign rb_err       = r_rb_err;
    assign w_bus_active = (r_state == c_write) || (r_state == c_read);
`else
    assign w_bus_active = (r_state == c_write);
`endif

    // Readback data only matters when the check is built in.
    assign w_unused_readdata = ^av_readdata;

    // Bus and handshake outputs are decoded purely from registered state.
    always_comb begin
        av_chipselect = w_bus_active;
        av_write_n    = (r_state != c_write);
        av_address    = w_bus_active ? c_pio_addr : 2'b00;
        av_writedata  = (r_state == c_write) ? w_wdata_ext : 32'd0;
        ack_a         = (r_state == c_ack) && !r_last_grant;
        ack_b         = (r_state == c_ack) &&  r_last_grant;
        busy          = (r_state != c_idle);
        last_grant    = r_last_grant;
        shadow        = r_shadow;
    end

endmodule
`default_nettype wire

// File: tb/tb_pio_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : tb_pio_write_arbiter
// Description: Directed-vector bench for pio_write_arbiter with a simple PIO
//              slave model. Build with PIO_WRITE_ARBITER_READBACK_EN defined
//              to exercise the readback check as well.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_pio_write_arbiter;

`ifdef PIO_WRITE_ARBITER_READBACK_EN
    localparam int c_p = 4;
`else
    localparam int c_p = 3;
`endif
    // Negedges from request setup to the ack cycle.
    localparam int c_l = c_p - 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_a, req_b;
    logic [1:0]  wdata_a, wdata_b;
    logic        ack_a, ack_b;
    logic [1:0]  av_address;
    logic        av_chipselect, av_write_n;
    logic [31:0] av_writedata, av_readdata;
    logic        busy, last_grant;
    logic [1:0]  shadow;
`ifdef PIO_WRITE_ARBITER_READBACK_EN
    logic        rb_err;
`endif

    logic [1:0]  r_pio;
    logic        r_force_zero;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pio_write_arbiter #(.DATA_W(2), .PIO_ADDR(0)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_a         (req_a),
        .wdata_a       (wdata_a),
        .ack_a         (ack_a),
        .req_b         (req_b),
        .wdata_b       (wdata_b),
        .ack_b         (ack_b),
        .av_address    (av_address),
        .av_chipselect (av_chipselect),
        .av_write_n    (av_write_n),
        .av_writedata  (av_writedata),
        .av_readdata   (av_readdata),
        .busy          (busy),
        .last_grant    (last_grant),
        .shadow        (shadow)
`ifdef PIO_WRITE_ARBITER_READBACK_EN
        ,
        .rb_err        (rb_err)
`endif
    );

    // PIO slave: zero-wait-state data register at word address 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pio <= 2'b00;
        end else if (av_chipselect && !av_write_n && av_address == 2'd0) begin
            r_pio <= av_writedata[1:0];
        end
    end

    assign av_readdata = r_force_zero ? 32'd0 : {30'd0, r_pio};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req_a   = 1'b0;
        req_b   = 1'b0;
        nclk(2);
        reset_n = 1'b1;
    endtask

    int cnt_a, cnt_b, t_a, t_b;

    initial begin
        reset_n      = 1'b0;
        req_a        = 1'b0;
        req_b        = 1'b0;
        wdata_a      = 2'b00;
        wdata_b      = 2'b00;
        r_force_zero = 1'b0;

        // ---- reset values ----
        nclk(2);
        check("rst_cs",      av_chipselect, 1'b0);
        check("rst_wn",      av_write_n,    1'b1);
        check("rst_addr",    av_address,    2'd0);
        check("rst_wdata",   av_writedata,  32'd0);
        check("rst_ack_a",   ack_a,         1'b0);
        check("rst_ack_b",   ack_b,         1'b0);
        check("rst_busy",    busy,          1'b0);
        check("rst_lgrant",  last_grant,    1'b1);
        check("rst_shadow",  shadow,        2'b00);
        reset_n = 1'b1;
        nclk(1);

        // ---- single write from A ----
        req_a   = 1'b1;
        wdata_a = 2'b10;
        nclk(1);
        check("wr_cs",    av_chipselect, 1'b1);
        check("wr_wn",    av_write_n,    1'b0);
        check("wr_addr",  av_address,    2'd0);
        check("wr_wdata", av_writedata,  32'h2);
        check("wr_busy",  busy,          1'b1);
        check("wr_ack_a", ack_a,         1'b0);
`ifdef PIO_WRITE_ARBITER_READBACK_EN
        nclk(1);
        check("rd_cs",    av_chipselect, 1'b1);
        check("rd_wn",    av_write_n,    1'b1);
        check("rd_addr",  av_address,    2'd0);
`endif
        nclk(1);
        check("ack_a",        ack_a,         1'b1);
        check("ack_b_quiet",  ack_b,         1'b0);
        check("ack_shadow",   shadow,        2'b10);
        check("ack_cs",       av_chipselect, 1'b0);
        check("ack_wn",       av_write_n,    1'b1);
        check("ack_lgrant",   last_grant,    1'b0);
        req_a = 1'b0;
        nclk(1);
        check("post_busy",  busy,  1'b0);
        check("post_ack_a", ack_a, 1'b0);
`ifdef PIO_WRITE_ARBITER_READBACK_EN
        check("rb_ok",      rb_err, 1'b0);
`endif

        // ---- simultaneous requests, each held until acked ----
        do_reset();
        nclk(1);
        req_a   = 1'b1;
        wdata_a = 2'b01;
        req_b   = 1'b1;
        wdata_b = 2'b11;
        cnt_a = 0; cnt_b = 0; t_a = -1; t_b = -1;
        for (int i = 1; i <= 3 * c_p; i++) begin
            nclk(1);
            if (ack_a) begin cnt_a++; t_a = i; req_a = 1'b0; end
            if (ack_b) begin cnt_b++; t_b = i; req_b = 1'b0; end
        end
        check("both_cnt_a",  cnt_a,      1);
        check("both_cnt_b",  cnt_b,      1);
        check("both_t_a",    t_a,        c_l);
        check("both_t_b",    t_b,        c_l + c_p);
        check("both_shadow", shadow,     2'b11);
        check("both_lgrant", last_grant, 1'b1);

        // ---- continuous contention: strict alternation A,B,A,B ----
        do_reset();
        nclk(1);
        req_a   = 1'b1;
        wdata_a = 2'b01;
        req_b   = 1'b1;
        wdata_b = 2'b10;
        for (int i = 1; i <= 4 * c_p; i++) begin
            nclk(1);
            check("alt_ack_a", ack_a, ((i % c_p) == c_l) && (((i / c_p) % 2) == 0));
            check("alt_ack_b", ack_b, ((i % c_p) == c_l) && (((i / c_p) % 2) == 1));
        end
        req_a = 1'b0;
        req_b = 1'b0;
        nclk(c_p);
        check("alt_idle",   busy,   1'b0);
        check("alt_shadow", shadow, 2'b10);

        // ---- wdata changes after grant are ignored ----
        req_b   = 1'b1;
        wdata_b = 2'b01;
        nclk(1);
        check("hold_wdata0", av_writedata, 32'h1);
        wdata_b = 2'b00;
        #1;
        check("hold_wdata1", av_writedata, 32'h1);
        nclk(c_l - 1);
        check("hold_ack_b",   ack_b,  1'b1);
        check("hold_shadow",  shadow, 2'b01);
        req_b = 1'b0;
        nclk(c_p);

        // ---- reset mid-write aborts the transfer ----
        req_a   = 1'b1;
        wdata_a = 2'b11;
        nclk(1);
        check("abort_pre_cs", av_chipselect, 1'b1);
        reset_n = 1'b0;
        req_a   = 1'b0;
        #2;
        reset_n = 1'b1;
        nclk(1);
        check("abort_cs",     av_chipselect, 1'b0);
        check("abort_wn",     av_write_n,    1'b1);
        check("abort_busy",   busy,          1'b0);
        check("abort_shadow", shadow,        2'b00);
        check("abort_ack_a",  ack_a,         1'b0);
        nclk(1);
        check("abort_ack_a2", ack_a,         1'b0);
        req_a   = 1'b1;
        wdata_a = 2'b10;
        nclk(1);
        check("fresh_wdata",  av_writedata,  32'h2);
        nclk(c_l - 1);
        check("fresh_ack_a",  ack_a,         1'b1);
        check("fresh_shadow", shadow,        2'b10);
        req_a = 1'b0;
        nclk(c_p);

`ifdef PIO_WRITE_ARBITER_READBACK_EN
        // ---- readback mismatch is sticky until reset ----
        do_reset();
        nclk(1);
        req_a   = 1'b1;
        wdata_a = 2'b01;
        nclk(c_l);
        check("rb_good_ack", ack_a,  1'b1);
        check("rb_good_err", rb_err, 1'b0);
        req_a = 1'b0;
        nclk(c_p);
        r_force_zero = 1'b1;
        req_a   = 1'b1;
        wdata_a = 2'b11;
        nclk(c_l);
        check("rb_bad_ack",  ack_a,  1'b1);
        check("rb_bad_err",  rb_err, 1'b1);
        req_a = 1'b0;
        nclk(c_p);
        r_force_zero = 1'b0;
        check("rb_sticky",   rb_err, 1'b1);
        req_a   = 1'b1;
        wdata_a = 2'b10;
        nclk(c_l);
        check("rb_sticky_ack", ack_a,  1'b1);
        check("rb_sticky2",    rb_err, 1'b1);
        req_a = 1'b0;
        do_reset();
        nclk(1);
        check("rb_cleared",  rb_err, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
